s_p: RTL and testbench
======================

S_P -- requirements
Module: s_p

Interface
REQ-001 Parameter: WIDTH, 16, bit width of each real and imaginary sample component (two's complement).
REQ-002 clk  input  1  sole clock; all state changes on posedge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  serial sample present on data_in_re/data_in_im this cycle.
REQ-005 data_in_re, data_in_im  input  WIDTH each  serial complex sample, natural order x[0]..x[15].
REQ-006 in_ready  output  1  block accepts a sample this cycle; a sample is accepted only when in_valid && in_ready.
REQ-007 s_p_flag_out  output  1  one-cycle pulse, 13 samples of current frame stored; drives the controller start input.
REQ-008 out_valid  output  1  parallel group valid.
REQ-009 group_idx  output  2  index g (0..3) of the group presented.
REQ-010 out0_re/im .. out3_re/im  output  WIDTH each  x[g], x[g+4], x[g+8], x[g+12].

Function
REQ-011 Write counter wr_cnt (4 bits) SHALL store each accepted sample at address wr_cnt, then increment it; 15 -> 0 wrap closes the frame.
REQ-012 in_valid low SHALL hold wr_cnt and buffer contents; input gaps of any length are legal.
REQ-013 s_p_flag_out SHALL be 1 exactly in the cycle after the 13th sample (address 12) of a frame is accepted, otherwise 0.
REQ-014 FSM states IDLE, FILL, READ: IDLE -> FILL on first accepted sample; FILL -> READ in the cycle after address 15 is accepted; READ lasts exactly 4 cycles, then -> FILL if wr_cnt != 0 else IDLE.
REQ-015 In READ, out_valid SHALL be 1 and group_idx SHALL step 0,1,2,3 on consecutive cycles with no stalls; first group appears the cycle after the 16th sample is accepted.
REQ-016 Outputs SHALL be registered; out* values SHALL be held (not zeroed) when out_valid is 0.
REQ-017 Data SHALL pass bit-exact; no scaling, rounding or sign extension.
REQ-018 If the 13th sample and READ of the previous frame coincide, both s_p_flag_out and out_valid SHALL assert; events are independent.

Reset
REQ-019 rst_n low SHALL immediately force: state IDLE, wr_cnt 0, s_p_flag_out 0, out_valid 0, group_idx 0, all out* 0, in_ready 1, bank pointer 0.
REQ-020 Buffer storage need not be cleared; a partial frame or READ in progress at reset SHALL be discarded with no further out_valid.
REQ-021 First accepted sample after reset release SHALL be x[0] of a new frame.

Configuration
REQ-022 Macro S_P_PINGPONG_EN defined: two 16-entry banks; writes go to the fill bank, READ uses the completed bank, banks swap at frame close; in_ready SHALL be constantly 1 after reset, allowing back-to-back frames.
REQ-023 Macro S_P_PINGPONG_EN undefined: single bank; in_ready SHALL be 0 during the 4 READ cycles and 1 otherwise; in_valid while in_ready is 0 SHALL be ignored with no change to wr_cnt or buffer.

Verification
REQ-024 Reset, then 16 continuous samples re=n, im=-n (n=0..15) -> s_p_flag_out pulses once, cycle after n=12; out_valid for 4 cycles starting the cycle after n=15; g=0 gives out0..3_re = 0,4,8,12, and g=3 gives 3,7,11,15.
REQ-025 Same frame with in_valid toggling 1,0 each cycle -> identical output values; flag and out_valid timing relative to the 13th and 16th accepted samples as in REQ-024.
REQ-026 With S_P_PINGPONG_EN, two back-to-back frames (n, then 100+n) -> in_ready stays 1; frame 2 READ outputs 100,104,108,112 at g=0 and frame 1 data is unaffected.
REQ-027 Without S_P_PINGPONG_EN, drive in_valid=1 continuously with 20 samples -> in_ready 0 for the 4 READ cycles; samples offered then are dropped; next accepted sample is stored at address 0.
REQ-028 Assert rst_n low after 9 accepted samples, release, send a full frame n=50..65 -> no flag or out_valid before the new 13th sample; g=0 outputs 50,54,58,62.

Source files
------------

// File: rtl/s_p.sv
// ---------------------------------------------------------------------------
// s_p -- serial-to-parallel buffer for a 16-point complex frame.
//
// Serial samples x[0]..x[15] are written into a 16-entry buffer in arrival
// order. Once a frame is complete, four parallel groups are presented on
// consecutive cycles: group g carries x[g], x[g+4], x[g+8], x[g+12].
//
// Optional build macro: S_P_PINGPONG_EN
//   defined   : two 16-entry banks; the next frame fills one bank while the
//               completed frame is read from the other, so in_ready stays 1.
//   undefined : single bank; input is back-pressured during the 4 READ cycles.
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_valid       serial sample present this cycle
//   data_in_re/im  serial complex sample (two's complement, WIDTH bits each)
//   in_ready       sample accepted when in_valid && in_ready
//   s_p_flag_out   one-cycle pulse after the 13th sample of a frame is stored
//   out_valid      parallel group valid
//   group_idx      index g (0..3) of the group presented
//   outK_re/im     x[g + 4*K], K = 0..3; held when out_valid is 0
// ---------------------------------------------------------------------------
module s_p #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] data_in_re,
  input  logic signed [WIDTH-1:0] data_in_im,
  output logic                    in_ready,
  output logic                    s_p_flag_out,
  output logic                    out_valid,
  output logic [1:0]              group_idx,
  output logic signed [WIDTH-1:0] out0_re,
  output logic signed [WIDTH-1:0] out0_im,
  output logic signed [WIDTH-1:0] out1_re,
  output logic signed [WIDTH-1:0] out1_im,
  output logic signed [WIDTH-1:0] out2_re,
  output logic signed [WIDTH-1:0] out2_im,
  output logic signed [WIDTH-1:0] out3_re,
  output logic signed [WIDTH-1:0] out3_im
);

`ifdef S_P_PINGPONG_EN
  localparam int DEPTH = 32;
`else
  localparam int DEPTH = 16;
`endif
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_READ = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              wr_cnt_q, wr_cnt_d;
  logic                    flag_q, flag_d;
  logic                    out_valid_q, out_valid_d;
  logic [1:0]              group_q, group_d;
  logic signed [WIDTH-1:0] out_re_q [4];
  logic signed [WIDTH-1:0] out_re_d [4];
  logic signed [WIDTH-1:0] out_im_q [4];
  logic signed [WIDTH-1:0] out_im_d [4];

  // Sample storage; deliberately not reset.
  logic signed [WIDTH-1:0] mem_re_q [DEPTH];
  logic signed [WIDTH-1:0] mem_im_q [DEPTH];

  logic                    accept;
  logic                    frame_close;
  logic [AW-1:0]           wr_addr;

`ifdef S_P_PINGPONG_EN
  logic bank_q, bank_d;
  logic rd_bank;

  assign in_ready = 1'b1;

  always_comb begin
    wr_addr = {bank_q, wr_cnt_q};
    bank_d  = frame_close ? ~bank_q : bank_q;
    // On the edge that enters READ the bank pointer has not swapped yet, so
    // the completed frame is still bank_q; once in READ it is the other one.
    rd_bank = (state_q == ST_READ) ? ~bank_q : bank_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
    end
  end
`else
  assign in_ready = (state_q != ST_READ);

  always_comb begin
    wr_addr = wr_cnt_q;
  end
`endif

  assign accept      = in_valid && in_ready;
  assign frame_close = accept && (wr_cnt_q == 4'd15);

  always_comb begin
    wr_cnt_d    = accept ? wr_cnt_q + 4'd1 : wr_cnt_q;
    flag_d      = accept && (wr_cnt_q == 4'd12);
    state_d     = state_q;
    out_valid_d = 1'b0;
    group_d     = group_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;

    case (state_q)
      ST_IDLE: if (accept)      state_d = ST_FILL;
      ST_FILL: if (frame_close) state_d = ST_READ;
      ST_READ: if (group_q == 2'd3) begin
        state_d = (wr_cnt_d != 4'd0) ? ST_FILL : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Output registers are loaded one edge ahead so that each READ cycle
    // presents its group directly from flops. group g, lane k is x[4k+g],
    // i.e. address {k, g} within the bank.
    if (state_d == ST_READ) begin
      out_valid_d = 1'b1;
      group_d     = (state_q == ST_READ) ? group_q + 2'd1 : 2'd0;
      for (int k = 0; k < 4; k++) begin
`ifdef S_P_PINGPONG_EN
        out_re_d[k] = mem_re_q[{rd_bank, 2'(k), group_d}];
        out_im_d[k] = mem_im_q[{rd_bank, 2'(k), group_d}];
`else
        out_re_d[k] = mem_re_q[{2'(k), group_d}];
        out_im_d[k] = mem_im_q[{2'(k), group_d}];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_cnt_q    <= 4'd0;
      flag_q      <= 1'b0;
      out_valid_q <= 1'b0;
      group_q     <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        out_re_q[k] <= '0;
        out_im_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      flag_q      <= flag_d;
      out_valid_q <= out_valid_d;
      group_q     <= group_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_re_q[wr_addr] <= data_in_re;
      mem_im_q[wr_addr] <= data_in_im;
    end
  end

  assign s_p_flag_out = flag_q;
  assign out_valid    = out_valid_q;
  assign group_idx    = group_q;
  assign out0_re      = out_re_q[0];
  assign out0_im      = out_im_q[0];
  assign out1_re      = out_re_q[1];
  assign out1_im      = out_im_q[1];
  assign out2_re      = out_re_q[2];
  assign out2_im      = out_im_q[2];
  assign out3_re      = out_re_q[3];
  assign out3_im      = out_im_q[3];

endmodule

// File: tb/tb_s_p.sv
// ---------------------------------------------------------------------------
// tb_s_p -- self-checking bench for s_p.
// Inputs are driven on the falling edge; outputs are checked 1 time unit
// later against a frame-level reference model (accepted-sample counter,
// frame array, snapshot of the completed frame, read position).
// ---------------------------------------------------------------------------
module tb_s_p;
  localparam int WIDTH = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic signed [WIDTH-1:0] data_in_re = '0;
  logic signed [WIDTH-1:0] data_in_im = '0;
  logic                    in_ready;
  logic                    s_p_flag_out;
  logic                    out_valid;
  logic [1:0]              group_idx;
  logic signed [WIDTH-1:0] out0_re, out0_im, out1_re, out1_im;
  logic signed [WIDTH-1:0] out2_re, out2_im, out3_re, out3_im;
  logic signed [WIDTH-1:0] o_re [4];
  logic signed [WIDTH-1:0] o_im [4];

  s_p #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .data_in_re(data_in_re), .data_in_im(data_in_im),
    .in_ready(in_ready), .s_p_flag_out(s_p_flag_out),
    .out_valid(out_valid), .group_idx(group_idx),
    .out0_re(out0_re), .out0_im(out0_im), .out1_re(out1_re), .out1_im(out1_im),
    .out2_re(out2_re), .out2_im(out2_im), .out3_re(out3_re), .out3_im(out3_im)
  );

  always #5 clk = ~clk;

  assign o_re[0] = out0_re; assign o_im[0] = out0_im;
  assign o_re[1] = out1_re; assign o_im[1] = out1_im;
  assign o_re[2] = out2_re; assign o_im[2] = out2_im;
  assign o_re[3] = out3_re; assign o_im[3] = out3_im;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int                      cnt;       // samples accepted in the current frame
  int                      rd_pos;    // group shown this cycle, -1 when none
  bit                      m_flag;    // expected flag this cycle
  logic signed [WIDTH-1:0] fr_re [16], fr_im [16];
  logic signed [WIDTH-1:0] sn_re [16], sn_im [16];
  logic signed [WIDTH-1:0] m_re [4], m_im [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready();
`ifdef S_P_PINGPONG_EN
    return 1'b1;
`else
    return (rd_pos < 0);
`endif
  endfunction

  task automatic model_reset();
    cnt    = 0;
    rd_pos = -1;
    m_flag = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_re[k] = '0;
      m_im[k] = '0;
    end
  endtask

  // Called just after a falling edge; leaves time just after the next one.
  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    model_reset();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_flag", s_p_flag_out, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_group_idx", group_idx, 2'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_out%0d_re", k), o_re[k], '0);
      chk($sformatf("rst_out%0d_im", k), o_im[k], '0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle(input bit v, input logic signed [WIDTH-1:0] re,
                       input logic signed [WIDTH-1:0] im);
    bit acc;
    int nxt_rd;
    in_valid   = v;
    data_in_re = re;
    data_in_im = im;
    #1;
    chk("in_ready", in_ready, exp_ready());
    chk("s_p_flag_out", s_p_flag_out, m_flag);
    chk("out_valid", out_valid, (rd_pos >= 0));
    if (rd_pos >= 0) begin
      chk("group_idx", group_idx, rd_pos);
      for (int k = 0; k < 4; k++) begin
        m_re[k] = sn_re[rd_pos + 4 * k];
        m_im[k] = sn_im[rd_pos + 4 * k];
      end
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out%0d_re", k), o_re[k], m_re[k]);
      chk($sformatf("out%0d_im", k), o_im[k], m_im[k]);
    end
    // Advance the model to the next cycle
    acc    = v && exp_ready();
    m_flag = acc && (cnt == 12);
    nxt_rd = (rd_pos >= 0 && rd_pos < 3) ? rd_pos + 1 : -1;
    if (acc) begin
      fr_re[cnt] = re;
      fr_im[cnt] = im;
      cnt++;
      if (cnt == 16) begin
        sn_re  = fr_re;
        sn_im  = fr_im;
        cnt    = 0;
        nxt_rd = 0;
      end
    end
    rd_pos = nxt_rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Ramp frame re=n, im=-n, continuous
    for (int n = 0; n < 16; n++) cycle(1'b1, WIDTH'(n), WIDTH'(-n));
    idle(6);

    // Same frame with in_valid toggling 1,0
    for (int n = 0; n < 16; n++) begin
      cycle(1'b1, WIDTH'(n), WIDTH'(-n));
      cycle(1'b0, 16'sh7777, 16'sh7777);
    end
    idle(6);

    // 20 continuous samples: back-pressure during READ (single bank)
    for (int n = 0; n < 20; n++) cycle(1'b1, WIDTH'(300 + n), WIDTH'(-300 - n));
    for (int n = 0; n < 16; n++) cycle(1'b1, WIDTH'(400 + n), WIDTH'(n));
    idle(6);

    // Reset after 9 samples, then frame 50..65
    for (int n = 0; n < 9; n++) cycle(1'b1, WIDTH'(200 + n), WIDTH'(n));
    do_reset();
    for (int n = 50; n < 66; n++) cycle(1'b1, WIDTH'(n), WIDTH'(-n));
    idle(6);

    // Reset while READ is in progress
    for (int n = 0; n < 16; n++) cycle(1'b1, WIDTH'(500 + n), WIDTH'(n));
    cycle(1'b0, '0, '0);
    do_reset();
    idle(6);

`ifdef S_P_PINGPONG_EN
    // Back-to-back frames n, then 100+n
    for (int n = 0; n < 16; n++) cycle(1'b1, WIDTH'(n), WIDTH'(-n));
    for (int n = 0; n < 16; n++) cycle(1'b1, WIDTH'(100 + n), WIDTH'(-100 - n));
    idle(6);
`endif

    // Random traffic, extreme values included
    for (int i = 0; i < 300; i++) begin
      logic signed [WIDTH-1:0] r, q;
      r = WIDTH'($urandom);
      q = WIDTH'($urandom);
      if ((i % 37) == 5)  r = 16'sh8000;
      if ((i % 41) == 7)  q = 16'sh7FFF;
      cycle(($urandom_range(0, 9) < 7), r, q);
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
